alu: RTL and testbench

Parameterised combinational integer ALU with a registered status-flag stage, used as the arithmetic/logic core of the Basys3 ALU design. The input and opcode registers sit upstream of this block. The result is a pure function of the current inputs with zero latency. Carry, zero, negative and overflow flags for the current result are captured on each clock edge for downstream consumers.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_if.sv | 28 ++
 rtl/alu_flag_reg.sv | 17 +
 rtl/alu.sv | 85 ++++++++
 tb/tb_alu.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: MIPS funct opcodes, default widths and
// the packed layout of the registered status flags.
package alu_pkg;

  localparam int NB_DATA_DEF   = 8;
  localparam int NB_OPCODE_DEF = 6;

  // MIPS funct codes selecting the operation
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

  // Status flags describing the previous cycle's result
  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the upstream input registers and the ALU.
interface alu_if
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF
);
  logic signed [NB_DATA-1:0]   i_op_1;
  logic signed [NB_DATA-1:0]   i_op_2;
  logic        [NB_OPCODE-1:0] i_opcode;
  logic signed [NB_DATA-1:0]   o_result;
  logic                        o_carry;
  logic                        o_zero;
  logic                        o_negative;
  logic                        o_overflow;

  // Side that supplies operands and consumes results/flags
  modport master (
    output i_op_1, i_op_2, i_opcode,
    input  o_result, o_carry, o_zero, o_negative, o_overflow
  );

  // ALU side
  modport slave (
    input  i_op_1, i_op_2, i_opcode,
    output o_result, o_carry, o_zero, o_negative, o_overflow
  );
endinterface

// File: rtl/alu_flag_reg.sv
// Four-bit status-flag register; reset clears all flags immediately.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  flags_t d,
  output flags_t q
);

  // Capture the next-values every edge; async clear on reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) q <= '0;
    else         q <= d;
  end

endmodule

// File: rtl/alu.sv
// Combinational integer ALU with a registered carry/zero/negative/overflow
// stage. The result path has no state; only the flags see the clock.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF
)(
  input  logic i_clk,
  input  logic i_reset,
  alu_if.slave bus
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] a;
  logic [NB_DATA-1:0] b;
  logic [NB_DATA-1:0] res;
  logic [NB_DATA:0]   wide;
  logic               carry;
  logic               ovf;
  logic               valid;
  flags_t             nxt;
  flags_t             flags;

  assign a = bus.i_op_1;
  assign b = bus.i_op_2;

  // One case on the opcode yields the result and the carry/overflow next-values.
  // Carry and borrow both come out of an NB_DATA+1 bit unsigned add/sub.
  always_comb begin
    res   = '0;
    wide  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    valid = 1'b1;
    case (bus.i_opcode)
      NB_OPCODE'(ADD): begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[MSB:0];
        carry = wide[NB_DATA];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      NB_OPCODE'(SUB): begin
        // top bit of the widened difference is the borrow (A < B unsigned)
        wide  = {1'b0, a} - {1'b0, b};
        res   = wide[MSB:0];
        carry = wide[NB_DATA];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      NB_OPCODE'(AND): res = a & b;
      NB_OPCODE'(OR):  res = a | b;
      NB_OPCODE'(XOR): res = a ^ b;
      NB_OPCODE'(NOR): res = ~(a | b);
      // Oversized shift amounts saturate naturally: >>> fills with the sign,
      // >> fills with zeros.
      NB_OPCODE'(SRA): res = $unsigned($signed(a) >>> b);
      NB_OPCODE'(SRL): res = a >> b;
      default:         valid = 1'b0;
    endcase
  end

  // Flag next-values; an unknown opcode forces every flag low, zero included
  always_comb begin
    nxt          = '0;
    nxt.carry    = carry;
    nxt.overflow = ovf;
    nxt.zero     = valid && (res == '0);
    nxt.negative = res[MSB];
  end

  alu_flag_reg u_flag_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .d       (nxt),
    .q       (flags)
  );

  assign bus.o_result   = res;
  assign bus.o_carry    = flags.carry;
  assign bus.o_zero     = flags.zero;
  assign bus.o_negative = flags.negative;
  assign bus.o_overflow = flags.overflow;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard of expected result/flags pushed at
// drive time, results compared combinationally, flags popped after the edge.
module tb_alu;

  localparam int NB = 8;
  localparam int NO = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_if #(.NB_DATA(NB), .NB_OPCODE(NO)) bus ();

  alu #(.NB_DATA(NB), .NB_OPCODE(NO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // flg packs {carry, zero, negative, overflow}
  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Golden model in plain signed/unsigned integer arithmetic
  function automatic exp_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ua = a;
    int   ub = b;
    int   sa = $signed(a);
    int   sb = $signed(b);
    int   r = 0;
    int   s = 0;
    bit   c = 0;
    bit   v = 0;
    bit   ok = 1;
    case (op)
      OP_ADD: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      OP_SUB: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOR: r = ~(ua | ub);
      OP_SRA: r = (ub >= NB) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      OP_SRL: r = (ub >= NB) ? 0 : (ua >> ub);
      default: ok = 0;
    endcase
    if (!ok) r = 0;
    e.res = r[7:0];
    e.flg = {c, ok && (e.res == 8'h00), e.res[7], v};
    return e;
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.o_carry, bus.o_zero, bus.o_negative, bus.o_overflow};
  endfunction

  // Drive between edges, push the expectation, compare the combinational result
  task automatic drive(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input string name);
    @(negedge clk);
    bus.i_opcode = op;
    bus.i_op_1   = a;
    bus.i_op_2   = b;
    sbq.push_back(model(op, a, b));
    #1;
    checks++;
    if (bus.o_result !== sbq[$].res) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, bus.o_result, sbq[$].res);
    end
  endtask

  // After the next rising edge, pop the oldest expectation and compare flags
  task automatic check_flags(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s flags: scoreboard empty, got %b want entry", name, flags_now());
    end else begin
      e = sbq.pop_front();
      if (flags_now() !== e.flg) begin
        errors++;
        $display("FAIL %s flags: got %b want %b", name, flags_now(), e.flg);
      end
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input string name);
    drive(op, a, b, name);
    check_flags(name);
  endtask

  // Explicit constant checks of the result and flags just observed
  task automatic expect_res(input logic [7:0] want, input string name);
    checks++;
    if (bus.o_result !== want) begin
      errors++;
      $display("FAIL %s const result: got %h want %h", name, bus.o_result, want);
    end
  endtask

  task automatic expect_flg(input logic [3:0] want, input string name);
    checks++;
    if (flags_now() !== want) begin
      errors++;
      $display("FAIL %s const flags: got %b want %b", name, flags_now(), want);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.i_opcode = OP_SUB;
    bus.i_op_1   = 8'h00;
    bus.i_op_2   = 8'h01;
    #1;
    expect_flg(4'b0000, "reset_async");
    expect_res(8'hFF, "reset_result_live");
    @(posedge clk);
    #1;
    expect_flg(4'b0000, "reset_held");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    step(OP_ADD, 8'h7F, 8'h01, "add_ovf");
    expect_res(8'h80, "add_ovf");
    expect_flg(4'b0011, "add_ovf");
    step(OP_SUB, 8'h00, 8'h01, "sub_borrow");
    expect_res(8'hFF, "sub_borrow");
    expect_flg(4'b1010, "sub_borrow");
    step(OP_ADD, 8'h80, 8'h80, "add_wrap_zero");
    expect_res(8'h00, "add_wrap_zero");
    expect_flg(4'b1101, "add_wrap_zero");
  endtask

  task automatic test_logic();
    step(OP_AND, 8'hC3, 8'h5A, "and"); expect_res(8'h42, "and");
    step(OP_OR,  8'hC3, 8'h5A, "or");  expect_res(8'hDB, "or");
    step(OP_XOR, 8'hC3, 8'h5A, "xor"); expect_res(8'h99, "xor");
    step(OP_NOR, 8'hC3, 8'h5A, "nor"); expect_res(8'h24, "nor");
  endtask

  task automatic test_shift();
    step(OP_SRA, 8'h90, 8'd2,  "sra2");   expect_res(8'hE4, "sra2");
    step(OP_SRL, 8'h90, 8'd2,  "srl2");   expect_res(8'h24, "srl2");
    step(OP_SRA, 8'h90, 8'd9,  "sra9");   expect_res(8'hFF, "sra9");
    step(OP_SRL, 8'h90, 8'd9,  "srl9");   expect_res(8'h00, "srl9");
    step(OP_SRA, 8'h90, 8'h80, "sra128"); expect_res(8'hFF, "sra128");
    expect_flg(4'b0010, "sra128");
  endtask

  task automatic test_invalid();
    step(OP_ADD, 8'h7F, 8'h01, "pre_invalid");
    step(6'b111111, 8'h00, 8'h00, "invalid");
    expect_res(8'h00, "invalid");
    expect_flg(4'b0000, "invalid");
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    step(OP_ADD, 8'h7F, 8'h01, "pre_reset");
    expect_flg(4'b0011, "pre_reset");
    #3;
    rst = 1'b1;
    #1;
    expect_flg(4'b0000, "mid_reset_drop");
    bus.i_opcode = OP_SUB;
    bus.i_op_1   = 8'h00;
    bus.i_op_2   = 8'h01;
    #1;
    expect_res(8'hFF, "mid_reset_result");
    @(posedge clk);
    #1;
    expect_flg(4'b0000, "mid_reset_hold");
    @(negedge clk);
    rst = 1'b0;
    e = model(OP_SUB, 8'h00, 8'h01);
    sbq.push_back(e);
    check_flags("reset_release");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      a  = 8'($urandom);
      b  = (op == OP_SRA || op == OP_SRL) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      step(op, a, b, "random");
    end
  endtask

  initial begin
    bus.i_opcode = '0;
    bus.i_op_1   = '0;
    bus.i_op_2   = '0;
    rst          = 1'b1;
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_invalid();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
